// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: conditions three raw buttons into press pulses and runs the
// run/pause/review controller that drives the counter levels and lap-memory strobes.
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LAP_DEPTH       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_stop,
  output logic       start,
  output logic       pause,
  output logic       stop,
  output logic       mem_write,
  output logic       mem_read,
  output logic [7:0] mem_address,
  output logic [7:0] lap_count,
  output logic       lap_full,
  output logic [1:0] state
);

  localparam int unsigned     CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]       DEPTH   = 8'(LAP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_REVIEW = 2'd3
  } state_t;

  // Button bit order: 0 = start, 1 = pause, 2 = stop.
  logic [2:0]       raw_s;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       stable_q, stable_d, stable_prev_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       press_s;
  logic             sel_start_s, sel_pause_s, sel_stop_s;

  state_t     state_q, state_d;
  logic [7:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] lap_count_q, lap_count_d;
  logic [7:0] mem_address_q, mem_address_d;
  logic       mem_write_q, mem_write_d;
  logic       mem_read_q, mem_read_d;
  logic       start_q, start_d;
  logic       pause_q, pause_d;
  logic       stop_q, stop_d;
  logic       lap_full_q, lap_full_d;

  assign raw_s = {btn_stop, btn_pause, btn_start};

  // Synchroniser, debounce and edge-detect registers for all three buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= 3'b000;
      sync2_q       <= 3'b000;
      stable_q      <= 3'b000;
      stable_prev_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_q       <= raw_s;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Debounce: a synced value is accepted only after it has differed for DEBOUNCE_CYCLES samples.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = {CNT_W{1'b0}};
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = {CNT_W{1'b0}};
        end else begin
          cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_d[i] = {CNT_W{1'b0}};
      end
    end
  end

  // Only the highest-priority press in a cycle survives: stop > start > pause.
  assign press_s     = stable_q & ~stable_prev_q;
  assign sel_stop_s  = press_s[2];
  assign sel_start_s = press_s[0] & ~press_s[2];
  assign sel_pause_s = press_s[1] & ~press_s[0] & ~press_s[2];

  // Controller state, lap pointers and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= 8'd0;
      rd_ptr_q      <= 8'd0;
      lap_count_q   <= 8'd0;
      mem_address_q <= 8'd0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      start_q       <= 1'b0;
      pause_q       <= 1'b0;
      stop_q        <= 1'b0;
      lap_full_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      lap_count_q   <= lap_count_d;
      mem_address_q <= mem_address_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      start_q       <= start_d;
      pause_q       <= pause_d;
      stop_q        <= stop_d;
      lap_full_q    <= lap_full_d;
    end
  end

  // Next-state, lap store/recall and output-level decode.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    lap_count_d   = lap_count_q;
    mem_address_d = mem_address_q;
    mem_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    start_d       = 1'b0;
    pause_d       = 1'b0;
    stop_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_start_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (sel_stop_s) begin
          state_d  = S_REVIEW;
          rd_ptr_d = 8'd0;
        end else if (sel_pause_s) begin
          state_d = S_PAUSED;
          // A full store is refused rather than overwriting the oldest lap.
          if (lap_count_q < DEPTH) begin
            mem_write_d   = 1'b1;
            mem_address_d = wr_ptr_q;
            wr_ptr_d      = wr_ptr_q + 8'd1;
            lap_count_d   = lap_count_q + 8'd1;
          end else begin
            mem_write_d = 1'b0;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_PAUSED: begin
        if (sel_stop_s) begin
          state_d  = S_REVIEW;
          rd_ptr_d = 8'd0;
        end else if (sel_start_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_PAUSED;
        end
      end
      S_REVIEW: begin
        if (sel_start_s) begin
          state_d       = S_IDLE;
          wr_ptr_d      = 8'd0;
          rd_ptr_d      = 8'd0;
          lap_count_d   = 8'd0;
          mem_address_d = 8'd0;
        end else if (sel_pause_s) begin
          state_d = S_REVIEW;
          if (lap_count_q != 8'd0) begin
            mem_read_d    = 1'b1;
            mem_address_d = rd_ptr_q;
            if (rd_ptr_q == lap_count_q - 8'd1) begin
              rd_ptr_d = 8'd0;
            end else begin
              rd_ptr_d = rd_ptr_q + 8'd1;
            end
          end else begin
            mem_read_d = 1'b0;
          end
        end else begin
          state_d = S_REVIEW;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_IDLE:   begin start_d = 1'b0; pause_d = 1'b0; stop_d = 1'b0; end
      S_RUN:    begin start_d = 1'b1; pause_d = 1'b0; stop_d = 1'b0; end
      S_PAUSED: begin start_d = 1'b1; pause_d = 1'b1; stop_d = 1'b0; end
      S_REVIEW: begin start_d = 1'b0; pause_d = 1'b0; stop_d = 1'b1; end
      default:  begin start_d = 1'b0; pause_d = 1'b0; stop_d = 1'b0; end
    endcase

    lap_full_d = (lap_count_d == DEPTH);
  end

  assign start       = start_q;
  assign pause       = pause_q;
  assign stop        = stop_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;
  assign lap_count   = lap_count_q;
  assign lap_full    = lap_full_q;
  assign state       = state_q;

endmodule
